// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module   : regfile_pkg
//  Brief    : Shared widths, index/data types and the hardwired-zero index
//             for the regfile_mp register file.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_DATA_WIDTH = 32;

    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module   : regfile_scoreboard
//  Brief    : Busy vector tracking outstanding producers; priority is
//             flush > issue-set > write-clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen_i,
    input  logic [ADDR_WIDTH-1:0]      waddr_i,
    input  logic                       issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]      issue_rd_i,
    input  logic                       flush_i,
    output logic [(2**ADDR_WIDTH)-1:0] busy_o,
    output logic                       busy_any_o
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Later assignments override earlier ones, which encodes the priority.
    always_comb begin
        busy_d = busy_q;
        if (wen_i && (waddr_i != ZERO_IDX)) begin
            busy_d[waddr_i] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != ZERO_IDX)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Multi-read-port register file (x0 hardwired to zero) with busy
//             scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int NUM_RPORTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RPORTS-1:0]            rbusy,
    input  logic                             issue_valid,
    input  logic [ADDR_WIDTH-1:0]            issue_rd,
    input  logic                             flush,
    output logic                             busy_any
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [NUM_REGS-1:0]   w_busy_vec;
    logic                  w_wr_act;

    assign w_wr_act = wen && (waddr != ZERO_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (w_wr_act) begin
            rf_q[waddr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wen_i         (wen),
        .waddr_i       (waddr),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .flush_i       (flush),
        .busy_o        (w_busy_vec),
        .busy_any_o    (busy_any)
    );

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        logic [ADDR_WIDTH-1:0] w_idx;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_busy;

        assign w_idx = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // x0 masking is applied last so it overrides any forwarded value.
        always_comb begin
            w_data = rf_q[w_idx];
            w_busy = w_busy_vec[w_idx];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_act && (w_idx == waddr)) begin
                w_data = wdata;
                w_busy = 1'b0;
            end
`endif
            if (w_idx == ZERO_IDX) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rbusy[p]                          = w_busy;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module   : tb_regfile_mp
//  Brief    : Self-checking bench for regfile_mp against an array-based
//             reference model; honours REGFILE_BYPASS_EN like the design.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int NR = 2**AW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wen = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [DW-1:0]    wdata = '0;
    logic [NP*AW-1:0] raddr = '0;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rbusy;
    logic             issue_valid = 1'b0;
    logic [AW-1:0]    issue_rd = '0;
    logic             flush = 1'b0;
    logic             busy_any;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_rf   [NR];
    bit            m_busy [NR];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RPORTS (NP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .busy_any    (busy_any)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply one rising edge to the model using the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (wen && waddr != 0) begin
            m_rf[waddr]   = wdata;
            m_busy[waddr] = 1'b0;
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // Compare every read port and busy_any against the model.
    task automatic check_ports(input string tag);
        logic [AW-1:0] idx;
        logic [DW-1:0] exp_d;
        logic          exp_b;
        bit            any;
        #1;
        for (int p = 0; p < NP; p++) begin
            idx = raddr[p*AW +: AW];
            if (idx == 0) begin
                exp_d = '0;
                exp_b = 1'b0;
            end else if (BYPASS && wen && waddr == idx) begin
                exp_d = wdata;
                exp_b = 1'b0;
            end else begin
                exp_d = m_rf[idx];
                exp_b = m_busy[idx];
            end
            compare($sformatf("%s.rdata%0d[x%0d]", tag, p, idx), rdata[p*DW +: DW], exp_d);
            compare($sformatf("%s.rbusy%0d[x%0d]", tag, p, idx), {31'b0, rbusy[p]}, {31'b0, exp_b});
        end
        any = 1'b0;
        for (int i = 0; i < NR; i++) any |= m_busy[i];
        compare($sformatf("%s.busy_any", tag), {31'b0, busy_any}, {31'b0, any});
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        model_reset();

        // Reset state on every index
        for (int i = 0; i < NR; i++) begin
            set_rd(AW'(i), AW'(NR - 1 - i));
            check_ports("reset");
        end
        @(negedge clk);
        rst = 1'b0;

        // Writes to x0 are dropped
        wen = 1'b1; waddr = 0; wdata = 32'hDEAD_BEEF;
        tick();
        wen = 1'b0;
        set_rd(0, 0);
        check_ports("x0_write");
        compare("x0_const", rdata[DW-1:0], 32'h0);

        // Basic write then read on both ports
        wen = 1'b1; waddr = 5; wdata = 32'h1234_5678;
        tick();
        wen = 1'b0;
        set_rd(5, 5);
        check_ports("wr_x5");
        compare("x5_p0_const", rdata[DW-1:0], 32'h1234_5678);
        compare("x5_p1_const", rdata[2*DW-1:DW], 32'h1234_5678);

        // Issue then write
        issue_valid = 1'b1; issue_rd = 7;
        tick();
        issue_valid = 1'b0;
        set_rd(7, 0);
        check_ports("issue_x7");
        compare("x7_busy_const", {31'b0, rbusy[0]}, 32'h1);
        wen = 1'b1; waddr = 7; wdata = 32'h42;
        tick();
        wen = 1'b0;
        check_ports("wr_x7");
        compare("x7_data_const", rdata[DW-1:0], 32'h42);

        // Same-cycle issue and write: producer wins, data still written
        issue_valid = 1'b1; issue_rd = 3; wen = 1'b1; waddr = 3; wdata = 32'h3333;
        tick();
        issue_valid = 1'b0; wen = 1'b0;
        set_rd(3, 3);
        check_ports("iss_wr_x3");
        compare("x3_busy_const", {31'b0, rbusy[1]}, 32'h1);
        compare("x3_data_const", rdata[DW-1:0], 32'h3333);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 3;
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        check_ports("flush_iss_x3");
        compare("x3_flush_const", {31'b0, rbusy[0]}, 32'h0);

        // Bypass window
        wen = 1'b1; waddr = 9; wdata = 32'h1111;
        tick();
        issue_valid = 1'b1; issue_rd = 9;
        tick();
        issue_valid = 1'b0;
        wdata = 32'hCAFE;
        set_rd(9, 9);
        check_ports("bypass_cycle");
        compare("bypass_const", rdata[DW-1:0], BYPASS ? 32'hCAFE : 32'h1111);
        compare("bypass_busy_const", {31'b0, rbusy[0]}, BYPASS ? 32'h0 : 32'h1);
        tick();
        wen = 1'b0;
        check_ports("bypass_next");
        compare("bypass_next_const", rdata[DW-1:0], 32'hCAFE);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            wen         = ($urandom_range(0, 1) == 1);
            waddr       = AW'($urandom_range(0, NR - 1));
            wdata       = $urandom;
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_rd    = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
            flush       = ($urandom_range(0, 15) == 0);
            set_rd(($urandom_range(0, 4) == 0) ? waddr : AW'($urandom_range(0, NR - 1)),
                   ($urandom_range(0, 4) == 0) ? waddr : AW'($urandom_range(0, NR - 1)));
            check_ports("rand");
            tick();
        end
        wen = 1'b0; issue_valid = 1'b0; flush = 1'b0;

        // Asynchronous reset between edges
        wen = 1'b1; waddr = 10; wdata = 32'hFF;
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_rd = AW'(r);
            tick();
            wen = 1'b0;
        end
        issue_valid = 1'b0;
        set_rd(10, 1);
        check_ports("pre_reset");
        compare("pre_reset_busy_any", {31'b0, busy_any}, 32'h1);
        #1 rst = 1'b1;
        model_reset();
        check_ports("mid_reset");
        compare("mid_reset_busy_any", {31'b0, busy_any}, 32'h0);
        compare("mid_reset_x10", rdata[DW-1:0], 32'h0);
        #1 rst = 1'b0;
        tick();
        check_ports("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
